// File: rtl/serial_prefetcher.sv
// Serial instruction prefetcher: issues fetch commands over a narrow serial link,
// reassembles returned words into a small queue and discards stale words after a redirect.
module serial_prefetcher #(
  parameter int IO_BITS = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int DEPTH = 2,
  localparam int W = IO_BITS * PAYLOAD_CYCLES,
  parameter logic [W-1:0] PC_RESET = 16'hfffc
) (
  input  logic               clk,
  input  logic               reset,
  output logic [W-1:0]       inst_o,
  output logic               inst_valid_o,
  input  logic               inst_done_i,
  input  logic               redirect_i,
  input  logic [W-1:0]       redirect_pc_i,
  output logic               tx_cmd_valid_o,
  input  logic               tx_cmd_started_i,
  output logic [IO_BITS-1:0] tx_data_o,
  input  logic               tx_data_next_i,
  input  logic               rx_data_valid_i,
  input  logic [IO_BITS-1:0] rx_pins_i,
  input  logic               rx_done_i,
  output logic [W-1:0]       pc_o,
  output logic [3:0]         outstanding_o,
  output logic               discarding_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int INC = W / 8;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [3:0]       count_q, count_d;
  logic [3:0]       outstanding_q, outstanding_d;
  logic [3:0]       discardCnt_q, discardCnt_d;
  logic [W-1:0]     pc_q, pc_d;
  logic [W-1:0]     addrShift_q, addrShift_d;
  logic [W-1:0]     assembler_q, assembler_d;
  logic [W-1:0]     rxWord;
  logic [4:0]       credit;
  logic             push, pop, retire;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The word being completed already includes the beat on the pins this cycle.
  assign rxWord = {rx_pins_i, assembler_q[W-1:IO_BITS]};

  always_comb begin
    credit         = {1'b0, count_q} + {1'b0, outstanding_q};
    tx_cmd_valid_o = !reset && !redirect_i && (credit < 5'(DEPTH));
    tx_data_o      = reset ? '0 : addrShift_q[IO_BITS-1:0];
    inst_valid_o   = !reset && (count_q != 4'd0);
    inst_o         = mem_q[rdPtr_q];
  end

  assign pc_o          = pc_q;
  assign outstanding_o = outstanding_q;
  assign discarding_o  = (discardCnt_q != 4'd0);

  always_comb begin
    pop    = inst_done_i && (count_q != 4'd0) && !redirect_i;
    push   = rx_done_i && !redirect_i && (discardCnt_q == 4'd0) &&
             ((count_q < 4'(DEPTH)) || pop);
    retire = rx_done_i && (outstanding_q != 4'd0);

    pc_d          = pc_q;
    addrShift_d   = addrShift_q;
    assembler_d   = assembler_q;
    rdPtr_d       = rdPtr_q;
    wrPtr_d       = wrPtr_q;
    count_d       = count_q;
    discardCnt_d  = discardCnt_q;
    outstanding_d = outstanding_q + {3'b0, tx_cmd_started_i} - {3'b0, retire};

    if (rx_data_valid_i) begin
      assembler_d = rxWord;
    end

    // The shifter captures pc on start, so a later redirect cannot disturb the address in flight.
    if (tx_cmd_started_i) begin
      addrShift_d = pc_q;
      pc_d        = pc_q + W'(INC);
    end else if (tx_data_next_i) begin
      addrShift_d = addrShift_q >> IO_BITS;
    end

    if (redirect_i) begin
      pc_d         = redirect_pc_i;
      rdPtr_d      = '0;
      wrPtr_d      = '0;
      count_d      = '0;
      discardCnt_d = outstanding_d;
    end else begin
      if (rx_done_i && (discardCnt_q != 4'd0)) begin
        discardCnt_d = discardCnt_q - 4'd1;
      end
      if (push) begin
        wrPtr_d = nextPtr(wrPtr_q);
      end
      if (pop) begin
        rdPtr_d = nextPtr(rdPtr_q);
      end
      count_d = count_q + {3'b0, push} - {3'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= PC_RESET;
      addrShift_q   <= '0;
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discardCnt_q  <= '0;
    end else begin
      pc_q          <= pc_d;
      addrShift_q   <= addrShift_d;
      rdPtr_q       <= rdPtr_d;
      wrPtr_q       <= wrPtr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discardCnt_q  <= discardCnt_d;
    end
  end

  // Assembler and queue storage carry no reset; valid data is tracked by the counters.
  always_ff @(posedge clk) begin
    assembler_q <= assembler_d;
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wrPtr_q] <= rxWord;
    end
  end

endmodule

// File: tb/tb_serial_prefetcher.sv
// Directed bench for serial_prefetcher: fetch, fill, redirect/discard, full-queue push+pop,
// mid-transfer reset, and two extra parameterisations driven in loopback.
module tb_serial_prefetcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        reset, redirect, txStarted, txNext, rxValid, rxDone, instDone;
  logic [15:0] redirectPc;
  logic [1:0]  rxPins;
  logic [15:0] inst, pc;
  logic        instValid, txCmdValid, discarding;
  logic [1:0]  txData;
  logic [3:0]  outstanding;

  serial_prefetcher dut (
    .clk(clk), .reset(reset),
    .inst_o(inst), .inst_valid_o(instValid), .inst_done_i(instDone),
    .redirect_i(redirect), .redirect_pc_i(redirectPc),
    .tx_cmd_valid_o(txCmdValid), .tx_cmd_started_i(txStarted),
    .tx_data_o(txData), .tx_data_next_i(txNext),
    .rx_data_valid_i(rxValid), .rx_pins_i(rxPins), .rx_done_i(rxDone),
    .pc_o(pc), .outstanding_o(outstanding), .discarding_o(discarding)
  );

  logic        swReset[2], swStart[2], swNext[2], swRxValid[2], swRxDone[2], swDone[2], swRedir[2];
  logic [15:0] swRedirPc[2];
  logic        swCmdValid[2], swInstValid[2], swDisc[2];
  logic [15:0] swInst[2], swPc[2];
  logic [3:0]  swOut[2];
  logic [0:0]  swTxA, swPinsA;
  logic [3:0]  swTxB, swPinsB;

  serial_prefetcher #(.IO_BITS(1), .PAYLOAD_CYCLES(16), .DEPTH(1), .PC_RESET(16'hfffc)) dutA (
    .clk(clk), .reset(swReset[0]),
    .inst_o(swInst[0]), .inst_valid_o(swInstValid[0]), .inst_done_i(swDone[0]),
    .redirect_i(swRedir[0]), .redirect_pc_i(swRedirPc[0]),
    .tx_cmd_valid_o(swCmdValid[0]), .tx_cmd_started_i(swStart[0]),
    .tx_data_o(swTxA), .tx_data_next_i(swNext[0]),
    .rx_data_valid_i(swRxValid[0]), .rx_pins_i(swPinsA), .rx_done_i(swRxDone[0]),
    .pc_o(swPc[0]), .outstanding_o(swOut[0]), .discarding_o(swDisc[0])
  );

  serial_prefetcher #(.IO_BITS(4), .PAYLOAD_CYCLES(4), .DEPTH(4), .PC_RESET(16'hfffc)) dutB (
    .clk(clk), .reset(swReset[1]),
    .inst_o(swInst[1]), .inst_valid_o(swInstValid[1]), .inst_done_i(swDone[1]),
    .redirect_i(swRedir[1]), .redirect_pc_i(swRedirPc[1]),
    .tx_cmd_valid_o(swCmdValid[1]), .tx_cmd_started_i(swStart[1]),
    .tx_data_o(swTxB), .tx_data_next_i(swNext[1]),
    .rx_data_valid_i(swRxValid[1]), .rx_pins_i(swPinsB), .rx_done_i(swRxDone[1]),
    .pc_o(swPc[1]), .outstanding_o(swOut[1]), .discarding_o(swDisc[1])
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic shiftAddr(output logic [15:0] cap);
    cap = '0;
    for (int b = 0; b < 8; b++) begin
      cap = {txData, cap[15:2]};
      txNext = 1'b1;
      tick();
    end
    txNext = 1'b0;
  endtask

  task automatic issueCmd(output logic [15:0] cap);
    txStarted = 1'b1;
    tick();
    txStarted = 1'b0;
    shiftAddr(cap);
  endtask

  // Returns one word over the rx pins, first beat in the LSBs; extra events ride on the last beat.
  task automatic applyStimulus(input logic [15:0] w, input logic popOnLast,
                               input logic redirOnLast, input logic [15:0] newPc);
    for (int b = 0; b < 8; b++) begin
      rxValid = 1'b1;
      rxPins  = w[2*b +: 2];
      rxDone  = (b == 7);
      if (b == 7) begin
        instDone   = popOnLast;
        redirect   = redirOnLast;
        redirectPc = newPc;
      end
      tick();
    end
    rxValid  = 1'b0;
    rxDone   = 1'b0;
    instDone = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic runSweep(input int which);
    int          io, depth, beats, nOut;
    logic [15:0] sent[$];
    logic [15:0] cap, expAddr, shifted;
    logic [3:0]  beat;
    io      = (which == 0) ? 1 : 4;
    depth   = (which == 0) ? 1 : 4;
    beats   = 16 / io;
    expAddr = 16'hfffc;
    nOut    = 0;
    for (int round = 0; round < 2; round++) begin
      for (int k = 0; k <= depth; k++) begin
        checkOutput($sformatf("sw%0d_credit_r%0d_k%0d", which, round, k),
                    {15'b0, swCmdValid[which]}, {15'b0, (nOut < depth)});
        if (nOut < depth) begin
          swStart[which] = 1'b1;
          tick();
          swStart[which] = 1'b0;
          cap = '0;
          for (int b = 0; b < beats; b++) begin
            beat = (which == 0) ? {3'b0, swTxA} : swTxB;
            cap  = (cap >> io) | ({12'b0, beat} << (16 - io));
            swNext[which] = 1'b1;
            tick();
          end
          swNext[which] = 1'b0;
          checkOutput($sformatf("sw%0d_addr_r%0d_k%0d", which, round, k), cap, expAddr);
          sent.push_back(cap);
          expAddr = expAddr + 16'd2;
          nOut++;
        end
      end
      checkOutput($sformatf("sw%0d_outstanding_r%0d", which, round), {12'b0, swOut[which]}, 16'(nOut));
      for (int i = 0; i < nOut; i++) begin
        for (int b = 0; b < beats; b++) begin
          shifted = sent[i] >> (b * io);
          swPinsA = shifted[0];
          swPinsB = shifted[3:0];
          swRxValid[which] = 1'b1;
          swRxDone[which]  = (b == beats - 1);
          tick();
        end
        swRxValid[which] = 1'b0;
        swRxDone[which]  = 1'b0;
      end
      for (int i = 0; i < nOut; i++) begin
        checkOutput($sformatf("sw%0d_inst_r%0d_i%0d", which, round, i), swInst[which], sent[i]);
        swDone[which] = 1'b1;
        tick();
        swDone[which] = 1'b0;
      end
      checkOutput($sformatf("sw%0d_drained_r%0d", which, round), {15'b0, swInstValid[which]}, 16'd0);
      sent.delete();
      nOut = 0;
    end
    checkOutput($sformatf("sw%0d_pc", which), swPc[which], expAddr);
    checkOutput($sformatf("sw%0d_discarding", which), {15'b0, swDisc[which]}, 16'd0);
  endtask

  initial begin
    logic [15:0] addr;
    for (int i = 0; i < 2; i++) begin
      swReset[i] = 1'b1; swStart[i] = 1'b0; swNext[i] = 1'b0; swRxValid[i] = 1'b0;
      swRxDone[i] = 1'b0; swDone[i] = 1'b0; swRedir[i] = 1'b0; swRedirPc[i] = '0;
    end
    swPinsA = '0;
    swPinsB = '0;

    // Reset with rx/tx strobes active: they must be ignored.
    reset = 1'b1; redirect = 1'b0; redirectPc = '0; txStarted = 1'b0; txNext = 1'b1;
    rxValid = 1'b1; rxPins = 2'b11; rxDone = 1'b1; instDone = 1'b0;
    tick();
    tick();
    checkOutput("rst_inst_valid", {15'b0, instValid}, 16'd0);
    checkOutput("rst_cmd_valid", {15'b0, txCmdValid}, 16'd0);
    checkOutput("rst_tx_data", {14'b0, txData}, 16'd0);
    checkOutput("rst_outstanding", {12'b0, outstanding}, 16'd0);
    checkOutput("rst_discarding", {15'b0, discarding}, 16'd0);
    checkOutput("rst_pc", pc, 16'hfffc);
    txNext = 1'b0; rxValid = 1'b0; rxDone = 1'b0; rxPins = '0;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) swReset[i] = 1'b0;
    tick();
    checkOutput("idle_cmd_valid", {15'b0, txCmdValid}, 16'd1);

    issueCmd(addr);
    checkOutput("fetch0_addr", addr, 16'hfffc);
    checkOutput("fetch0_pc", pc, 16'hfffe);
    checkOutput("fetch0_outstanding", {12'b0, outstanding}, 16'd1);
    issueCmd(addr);
    checkOutput("fetch1_addr", addr, 16'hfffe);
    checkOutput("fetch1_pc", pc, 16'h0000);
    checkOutput("fetch1_outstanding", {12'b0, outstanding}, 16'd2);
    checkOutput("fetch1_cmd_valid", {15'b0, txCmdValid}, 16'd0);

    applyStimulus(16'h1234, 1'b0, 1'b0, 16'h0);
    checkOutput("fill1_inst_valid", {15'b0, instValid}, 16'd1);
    checkOutput("fill1_inst", inst, 16'h1234);
    checkOutput("fill1_outstanding", {12'b0, outstanding}, 16'd1);
    checkOutput("fill1_cmd_valid", {15'b0, txCmdValid}, 16'd0);
    applyStimulus(16'h5678, 1'b0, 1'b0, 16'h0);
    checkOutput("fill2_inst", inst, 16'h1234);
    checkOutput("fill2_cmd_valid", {15'b0, txCmdValid}, 16'd0);
    checkOutput("fill2_outstanding", {12'b0, outstanding}, 16'd0);

    // Full queue: push and pop on the same edge keep two entries.
    applyStimulus(16'h9abc, 1'b1, 1'b0, 16'h0);
    checkOutput("full_inst", inst, 16'h5678);
    checkOutput("full_inst_valid", {15'b0, instValid}, 16'd1);
    checkOutput("full_cmd_valid", {15'b0, txCmdValid}, 16'd0);
    checkOutput("full_outstanding", {12'b0, outstanding}, 16'd0);
    instDone = 1'b1; tick(); instDone = 1'b0;
    checkOutput("full_next_inst", inst, 16'h9abc);
    checkOutput("full_next_cmd_valid", {15'b0, txCmdValid}, 16'd1);
    instDone = 1'b1; tick(); instDone = 1'b0;
    checkOutput("drain_inst_valid", {15'b0, instValid}, 16'd0);
    instDone = 1'b1; tick(); instDone = 1'b0;
    checkOutput("empty_pop_inst_valid", {15'b0, instValid}, 16'd0);
    checkOutput("empty_pop_cmd_valid", {15'b0, txCmdValid}, 16'd1);

    // Redirect with two commands in flight.
    issueCmd(addr);
    checkOutput("pre_redir_addr0", addr, 16'h0000);
    issueCmd(addr);
    checkOutput("pre_redir_addr1", addr, 16'h0002);
    redirect = 1'b1; redirectPc = 16'h0100;
    tick();
    redirect = 1'b0;
    checkOutput("redir_discarding", {15'b0, discarding}, 16'd1);
    checkOutput("redir_pc", pc, 16'h0100);
    checkOutput("redir_outstanding", {12'b0, outstanding}, 16'd2);
    checkOutput("redir_inst_valid", {15'b0, instValid}, 16'd0);
    applyStimulus(16'haaaa, 1'b0, 1'b0, 16'h0);
    checkOutput("drop1_inst_valid", {15'b0, instValid}, 16'd0);
    checkOutput("drop1_discarding", {15'b0, discarding}, 16'd1);
    checkOutput("drop1_cmd_valid", {15'b0, txCmdValid}, 16'd1);
    applyStimulus(16'hbbbb, 1'b0, 1'b0, 16'h0);
    checkOutput("drop2_inst_valid", {15'b0, instValid}, 16'd0);
    checkOutput("drop2_discarding", {15'b0, discarding}, 16'd0);
    checkOutput("drop2_outstanding", {12'b0, outstanding}, 16'd0);
    issueCmd(addr);
    checkOutput("redir_addr", addr, 16'h0100);

    // Redirect coinciding with rx_done: the landing word is dropped and not counted.
    issueCmd(addr);
    checkOutput("same_pre_addr", addr, 16'h0102);
    checkOutput("same_pre_outstanding", {12'b0, outstanding}, 16'd2);
    applyStimulus(16'hcccc, 1'b0, 1'b1, 16'h0200);
    checkOutput("same_discarding", {15'b0, discarding}, 16'd1);
    checkOutput("same_outstanding", {12'b0, outstanding}, 16'd1);
    checkOutput("same_inst_valid", {15'b0, instValid}, 16'd0);
    checkOutput("same_pc", pc, 16'h0200);
    applyStimulus(16'hdddd, 1'b0, 1'b0, 16'h0);
    checkOutput("same_drop_inst_valid", {15'b0, instValid}, 16'd0);
    checkOutput("same_drop_discarding", {15'b0, discarding}, 16'd0);
    issueCmd(addr);
    checkOutput("same_next_addr", addr, 16'h0200);
    applyStimulus(16'heeee, 1'b0, 1'b0, 16'h0);
    checkOutput("same_next_inst_valid", {15'b0, instValid}, 16'd1);
    checkOutput("same_next_inst", inst, 16'heeee);

    // Redirect together with inst_done and a command start.
    redirect = 1'b1; redirectPc = 16'h0300; instDone = 1'b1; txStarted = 1'b1;
    #1;
    checkOutput("redir_blocks_cmd_valid", {15'b0, txCmdValid}, 16'd0);
    tick();
    redirect = 1'b0; instDone = 1'b0; txStarted = 1'b0;
    checkOutput("rs_inst_valid", {15'b0, instValid}, 16'd0);
    checkOutput("rs_outstanding", {12'b0, outstanding}, 16'd1);
    checkOutput("rs_discarding", {15'b0, discarding}, 16'd1);
    checkOutput("rs_pc", pc, 16'h0300);
    shiftAddr(addr);
    checkOutput("rs_addr_kept", addr, 16'h0202);
    applyStimulus(16'h1111, 1'b0, 1'b0, 16'h0);
    checkOutput("rs_drop_discarding", {15'b0, discarding}, 16'd0);
    checkOutput("rs_drop_inst_valid", {15'b0, instValid}, 16'd0);
    checkOutput("rs_drop_outstanding", {12'b0, outstanding}, 16'd0);

    // Reset in the middle of an address transfer and a receive.
    txStarted = 1'b1; tick(); txStarted = 1'b0;
    txNext = 1'b1; tick(); tick(); tick();
    rxValid = 1'b1; rxPins = 2'b10; reset = 1'b1;
    tick();
    checkOutput("rstmid_outstanding", {12'b0, outstanding}, 16'd0);
    checkOutput("rstmid_tx_data", {14'b0, txData}, 16'd0);
    checkOutput("rstmid_pc", pc, 16'hfffc);
    checkOutput("rstmid_cmd_valid", {15'b0, txCmdValid}, 16'd0);
    reset = 1'b0; txNext = 1'b0; rxValid = 1'b0; rxPins = '0;
    tick();
    issueCmd(addr);
    checkOutput("rstmid_first_addr", addr, 16'hfffc);

    runSweep(0);
    runSweep(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
